// File: rtl/cpu_types_pkg.sv
// Shared types for the memory subsystem: RAM handshake state, data word and the
// coherence controller FSM encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {IDLE, ARB, SNOOP, C2C, LOAD, WB, IFETCH} cc_state_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coherence_control_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_valid
);

    int idx;

    // Walk offsets from the far end so the closest requester to ptr wins last.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt_idx   = PW'(idx);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coherence_control.sv
// Shared-RAM arbiter for CPUS cores with MSI snooping between dcaches; block
// transfers are served from RAM or forwarded cache-to-cache from a dirty owner.
module coherence_control
    import cpu_types_pkg::*;
#(
    parameter int CPUS        = 2,
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BLOCK_WORDS = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [CPUS-1:0]               iREN,
    input  logic [CPUS-1:0][ADDR_W-1:0]   iaddr,
    output logic [CPUS-1:0]               iwait,
    output logic [CPUS-1:0][WORD_W-1:0]   iload,
    input  logic [CPUS-1:0]               dREN,
    input  logic [CPUS-1:0]               dWEN,
    input  logic [CPUS-1:0][ADDR_W-1:0]   daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]               dwait,
    output logic [CPUS-1:0][WORD_W-1:0]   dload,
    input  logic [CPUS-1:0]               cctrans,
    input  logic [CPUS-1:0]               ccwrite,
    input  logic [CPUS-1:0]               ccdirty,
    output logic [CPUS-1:0]               ccwait,
    output logic [CPUS-1:0]               ccinv,
    output logic [ADDR_W-1:0]             ccsnoopaddr,
    output logic                          ramREN,
    output logic                          ramWEN,
    output logic [ADDR_W-1:0]             ramaddr,
    output logic [WORD_W-1:0]             ramstore,
    input  logic [WORD_W-1:0]             ramload,
    input  ramstate_t                     ramstate
);

    localparam int GW  = idx_w(CPUS);
    localparam int WCW = idx_w(BLOCK_WORDS);

    cc_state_t       state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d, rr_q, rr_d, snp_q, snp_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic            sphase_q, sphase_d;
    logic [CPUS-1:0] ccwait_q, ccwait_d, ccinv_q, ccinv_d;
    logic            ramren_q, ramren_d, ramwen_q, ramwen_d;

    logic [CPUS-1:0] dreq, dirty_mask, dgrant;
    logic [GW-1:0]   dirty_idx, d_idx, i_idx;
    logic            d_vld, i_vld, xfer_done, ram_acc;

    assign dreq    = dREN | dWEN;
    assign ram_acc = (ramstate == ACCESS);

    rr_arbiter #(.N(CPUS), .PW(GW)) u_darb (
        .req      (dreq),
        .ptr      (rr_q),
        .gnt_idx  (d_idx),
        .gnt_valid(d_vld)
    );

    rr_arbiter #(.N(CPUS), .PW(GW)) u_iarb (
        .req      (iREN),
        .ptr      (rr_q),
        .gnt_idx  (i_idx),
        .gnt_valid(i_vld)
    );

    // The requester itself is never a valid supplier of its own miss.
    always_comb begin
        dirty_mask = '0;
        dirty_idx  = '0;
        for (int j = 0; j < CPUS; j++) begin
            dirty_mask[j] = ccdirty[j] && (GW'(j) != gnt_q);
        end
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (dirty_mask[j]) begin
                dirty_idx = GW'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        wcnt_d    = wcnt_q;
        snp_d     = snp_q;
        sphase_d  = 1'b0;
        xfer_done = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|dreq) || (|iREN)) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (d_vld) begin
                    gnt_d = d_idx;
                    if (dWEN[d_idx] && !cctrans[d_idx]) begin
                        state_d = WB;
                    end else if (cctrans[d_idx] && (CPUS > 1)) begin
                        state_d = SNOOP;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (i_vld) begin
                    gnt_d   = i_idx;
                    state_d = IFETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            SNOOP: begin
                if (!sphase_q) begin
                    sphase_d = 1'b1;
                end else if (|dirty_mask) begin
                    snp_d   = dirty_idx;
                    state_d = C2C;
                end else begin
                    state_d = LOAD;
                end
            end
            C2C, LOAD, WB: begin
                if (ram_acc) begin
                    if (wcnt_q == WCW'(BLOCK_WORDS - 1)) begin
                        xfer_done = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            IFETCH: begin
                xfer_done = ram_acc;
            end
            default: state_d = IDLE;
        endcase
        if (xfer_done) begin
            state_d = IDLE;
            wcnt_d  = '0;
            rr_d    = (gnt_q == GW'(CPUS - 1)) ? '0 : gnt_q + 1'b1;
        end
    end

    // Strobes are decoded from the next state so they leave the flops glitch-free.
    always_comb begin
        ramren_d = (state_d == LOAD) || (state_d == IFETCH);
        ramwen_d = (state_d == WB) || (state_d == C2C);
        ccwait_d = '0;
        ccinv_d  = '0;
        for (int j = 0; j < CPUS; j++) begin
            if (state_d == SNOOP) begin
                ccwait_d[j] = (GW'(j) != gnt_d);
                ccinv_d[j]  = (GW'(j) != gnt_d) && ccwrite[gnt_d];
            end else if (state_d == C2C) begin
                ccwait_d[j] = (GW'(j) == snp_d);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_q     <= '0;
            wcnt_q   <= '0;
            snp_q    <= '0;
            sphase_q <= 1'b0;
            ccwait_q <= '0;
            ccinv_q  <= '0;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            wcnt_q   <= wcnt_d;
            snp_q    <= snp_d;
            sphase_q <= sphase_d;
            ccwait_q <= ccwait_d;
            ccinv_q  <= ccinv_d;
            ramren_q <= ramren_d;
            ramwen_q <= ramwen_d;
        end
    end

    assign ramREN      = ramren_q;
    assign ramWEN      = ramwen_q;
    assign ccwait      = ccwait_q;
    assign ccinv       = ccinv_q;
    assign ccsnoopaddr = (state_q == SNOOP) ? daddr[gnt_q] : '0;

    always_comb begin
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            LOAD:    ramaddr = daddr[gnt_q];
            IFETCH:  ramaddr = iaddr[gnt_q];
            WB: begin
                ramaddr  = daddr[gnt_q];
                ramstore = dstore[gnt_q];
            end
            C2C: begin
                ramaddr  = daddr[snp_q];
                ramstore = dstore[snp_q];
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < CPUS; gi++) begin : g_core
        logic is_gnt;
        assign is_gnt      = (gnt_q == GW'(gi));
        assign dgrant[gi]  = (is_gnt && (state_q inside {LOAD, WB, C2C}))
                           || ((state_q == C2C) && (snp_q == GW'(gi)));
        assign dwait[gi]   = dreq[gi] & ~(dgrant[gi] & ram_acc);
        assign iwait[gi]   = iREN[gi] & ~(is_gnt && (state_q == IFETCH) && ram_acc);
        assign dload[gi]   = !is_gnt            ? '0 :
                             (state_q == LOAD)  ? ramload :
                             (state_q == C2C)   ? dstore[snp_q] : '0;
        assign iload[gi]   = (is_gnt && (state_q == IFETCH)) ? ramload : '0;
    end

    // Requesters must hold their strobe until the final word is acknowledged.
    a_dreq_held: assert property (@(posedge CLK) disable iff (RST)
        (state_q inside {SNOOP, C2C, LOAD, WB}) |-> dreq[gnt_q]);
    a_ireq_held: assert property (@(posedge CLK) disable iff (RST)
        (state_q == IFETCH) |-> iREN[gnt_q]);

endmodule

// File: tb/tb_coherence_control.sv
// Directed bench for coherence_control with CPUS=2, BLOCK_WORDS=2; expected
// values are hand-derived constants per cycle.
module tb_coherence_control;
    import cpu_types_pkg::*;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [1:0]            iREN, dREN, dWEN, cctrans, ccwrite, ccdirty;
    logic [1:0][31:0]      iaddr, daddr, dstore;
    logic [1:0]            iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0]      iload, dload;
    logic [31:0]           ccsnoopaddr, ramaddr, ramstore, ramload;
    logic                  ramREN, ramWEN;
    ramstate_t             ramstate;

    int tests_run    = 0;
    int tests_failed = 0;

    coherence_control #(.CPUS(2), .WORD_W(32), .ADDR_W(32), .BLOCK_WORDS(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccdirty(ccdirty),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ccdirty = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        // Reset state; waits follow raw requests while held in reset
        iREN = 2'b01;
        #2;
        check("rst_iwait", iwait, 2'b01);
        check("rst_ramREN", ramREN, 1'b0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ccwait", ccwait, 2'b00);
        check("rst_state", dut.state_q, IDLE);
        iREN = '0;
        step(); step();
        RST = 1'b0;
        $display("[TB] reset released");

        // Two icache fetches, round-robin from rr=0
        iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h180;
        ramstate = ACCESS; ramload = 32'hDEAD;
        #1;
        check("if_idle_iwait", iwait, 2'b11);
        step();
        check("if_arb_state", dut.state_q, ARB);
        step();
        check("if0_ramREN", ramREN, 1'b1);
        check("if0_ramaddr", ramaddr, 32'h100);
        check("if0_iload0", iload[0], 32'hDEAD);
        check("if0_iload1", iload[1], 32'h0);
        check("if0_iwait", iwait, 2'b10);
        step();
        iREN = 2'b10;
        #1;
        check("if0_done_rr", dut.rr_q, 1);
        check("if0_done_iwait", iwait, 2'b10);
        $display("[TB] ifetch core0 addr 100");
        step(); step();
        ramload = 32'hBEEF;
        #1;
        check("if1_ramaddr", ramaddr, 32'h180);
        check("if1_iload1", iload[1], 32'hBEEF);
        check("if1_iwait", iwait, 2'b00);
        step();
        iREN = '0;
        #1;
        check("if1_done_rr", dut.rr_q, 0);
        $display("[TB] ifetch core1 addr 180");

        // Core1 writeback against core0 ifetch with rr=0: dcache class wins
        dWEN = 2'b10; cctrans = 2'b00; daddr[1] = 32'h400; dstore[1] = 32'h55;
        iREN = 2'b01; iaddr[0] = 32'h500;
        step(); step();
        check("wb_state", dut.state_q, WB);
        check("wb_ramWEN", ramWEN, 1'b1);
        check("wb_ramREN", ramREN, 1'b0);
        check("wb_ramaddr0", ramaddr, 32'h400);
        check("wb_ramstore0", ramstore, 32'h55);
        check("wb_dwait0", dwait, 2'b00);
        check("wb_iwait0", iwait, 2'b01);
        step();
        daddr[1] = 32'h404; dstore[1] = 32'h66; ramstate = BUSY;
        #1;
        for (int b = 0; b < 3; b++) begin
            check("wb_busy_dwait", dwait, 2'b10);
            check("wb_busy_wcnt", dut.wcnt_q, 1);
            step();
        end
        ramstate = ACCESS;
        #1;
        check("wb_w1_dwait", dwait, 2'b00);
        check("wb_w1_ramaddr", ramaddr, 32'h404);
        check("wb_w1_ramstore", ramstore, 32'h66);
        step();
        dWEN = '0;
        #1;
        check("wb_done_state", dut.state_q, IDLE);
        check("wb_done_rr", dut.rr_q, 0);
        $display("[TB] writeback core1 addr 400");
        step(); step();
        check("wbif_state", dut.state_q, IFETCH);
        check("wbif_ramaddr", ramaddr, 32'h500);
        check("wbif_iwait", iwait, 2'b00);
        step();
        iREN = '0;
        #1;
        check("wbif_done_rr", dut.rr_q, 1);
        $display("[TB] ifetch core0 addr 500");

        // Coherent read miss, no dirty snooper
        dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b00; daddr[0] = 32'h200; ccdirty = 2'b00;
        step(); step();
        check("rm_snp0_ccwait", ccwait, 2'b10);
        check("rm_snp0_ccinv", ccinv, 2'b00);
        check("rm_snp0_addr", ccsnoopaddr, 32'h200);
        check("rm_snp0_dwait", dwait, 2'b01);
        step();
        check("rm_snp1_ccwait", ccwait, 2'b10);
        check("rm_snp1_state", dut.state_q, SNOOP);
        step();
        ramload = 32'h11;
        #1;
        check("rm_ld0_state", dut.state_q, LOAD);
        check("rm_ld0_ramREN", ramREN, 1'b1);
        check("rm_ld0_ramaddr", ramaddr, 32'h200);
        check("rm_ld0_dload", dload[0], 32'h11);
        check("rm_ld0_dwait", dwait, 2'b00);
        check("rm_ld0_ccwait", ccwait, 2'b00);
        step();
        daddr[0] = 32'h204; ramload = 32'h22;
        #1;
        check("rm_ld1_ramaddr", ramaddr, 32'h204);
        check("rm_ld1_dload", dload[0], 32'h22);
        step();
        dREN = '0; cctrans = '0;
        #1;
        check("rm_done_state", dut.state_q, IDLE);
        $display("[TB] read miss core0 addr 200");

        // Write miss served cache-to-cache from dirty core1
        dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h300;
        daddr[1] = 32'h300; dstore[1] = 32'hA; ccdirty = 2'b10;
        step(); step();
        check("wm_snp_ccinv", ccinv, 2'b10);
        check("wm_snp_ccwait", ccwait, 2'b10);
        step(); step();
        check("wm_c2c_state", dut.state_q, C2C);
        check("wm_c2c_snp", dut.snp_q, 1);
        check("wm_c2c_ramWEN", ramWEN, 1'b1);
        check("wm_c2c_ramaddr0", ramaddr, 32'h300);
        check("wm_c2c_ramstore0", ramstore, 32'hA);
        check("wm_c2c_dload0", dload[0], 32'hA);
        check("wm_c2c_ccwait", ccwait, 2'b10);
        check("wm_c2c_dwait", dwait, 2'b00);
        step();
        daddr[1] = 32'h304; dstore[1] = 32'hB;
        #1;
        check("wm_c2c_ramaddr1", ramaddr, 32'h304);
        check("wm_c2c_ramstore1", ramstore, 32'hB);
        check("wm_c2c_dload1", dload[0], 32'hB);
        step();
        dREN = '0; cctrans = '0; ccwrite = '0; ccdirty = '0;
        #1;
        check("wm_done_state", dut.state_q, IDLE);
        check("wm_done_ramWEN", ramWEN, 1'b0);
        $display("[TB] write miss core0 addr 300 via c2c");

        // Asynchronous reset in the middle of a block load
        dREN = 2'b10; daddr[1] = 32'h600;
        step(); step();
        check("ar_ld_ramREN", ramREN, 1'b1);
        step();
        ramstate = BUSY;
        #1;
        check("ar_ld_wcnt", dut.wcnt_q, 1);
        #2;
        RST = 1'b1;
        #1;
        check("ar_ramREN", ramREN, 1'b0);
        check("ar_state", dut.state_q, IDLE);
        check("ar_wcnt", dut.wcnt_q, 0);
        check("ar_gnt", dut.gnt_q, 0);
        check("ar_rr", dut.rr_q, 0);
        check("ar_dwait", dwait, 2'b10);
        dREN = '0;
        step();
        RST = 1'b0;
        $display("[TB] reset during load");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
